// File: rtl/bias_stream_loader.sv
// Bias table loader: fills NUM_COEFF words from an ap_fifo stream, then serves them on a
// 1-cycle-latency memory port. Optional BIAS_LOADER_DRAIN_EN discards surplus stream words.
module bias_stream_loader #(
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_COEFF   = 32,
    localparam int ADDR_WIDTH = $clog2(NUM_COEFF)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [COEFF_WIDTH-1:0] input_V_dout,
    input  logic                   input_V_empty_n,
    output logic                   input_V_read,
    input  logic                   reload,
    input  logic [ADDR_WIDTH-1:0]  bias_V_address0,
    input  logic                   bias_V_ce0,
    output logic [COEFF_WIDTH-1:0] bias_V_q0,
`ifdef BIAS_LOADER_DRAIN_EN
    output logic [15:0]            drop_cnt,
`endif
    output logic                   loaded
);
    typedef enum logic {LOAD, READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_COEFF - 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic                   loaded_q, loaded_d;
    logic [COEFF_WIDTH-1:0] q0_q, q0_d;
    logic                   mem_we;
    logic                   addr_ok;
    logic [COEFF_WIDTH-1:0] mem [NUM_COEFF];
`ifdef BIAS_LOADER_DRAIN_EN
    logic [15:0]            drop_cnt_q, drop_cnt_d;
`endif

    // Widen by one bit so the bound check also works when NUM_COEFF is a power of two.
    assign addr_ok = ({1'b0, bias_V_address0} < (ADDR_WIDTH + 1)'(NUM_COEFF));

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        loaded_d     = loaded_q;
        q0_d         = q0_q;
        input_V_read = 1'b0;
        mem_we       = 1'b0;
`ifdef BIAS_LOADER_DRAIN_EN
        drop_cnt_d   = drop_cnt_q;
`endif
        case (state_q)
            LOAD: begin
                input_V_read = input_V_empty_n & ~reload;
                if (input_V_read) begin
                    mem_we = 1'b1;
                    if (wr_cnt_q == LAST_ADDR) begin
                        wr_cnt_d = '0;
                        state_d  = READY;
                        loaded_d = 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (bias_V_ce0)
                    q0_d = addr_ok ? mem[bias_V_address0] : '0;
`ifdef BIAS_LOADER_DRAIN_EN
                input_V_read = input_V_empty_n & ~reload;
                if (input_V_read && drop_cnt_q != 16'hFFFF)
                    drop_cnt_d = drop_cnt_q + 16'd1;
`endif
            end
            default: state_d = LOAD;
        endcase
        // Reload wins over the load/drain paths; the READY read above still uses the old table.
        if (reload) begin
            state_d  = LOAD;
            wr_cnt_d = '0;
            loaded_d = 1'b0;
`ifdef BIAS_LOADER_DRAIN_EN
            drop_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
            loaded_q <= 1'b0;
            q0_q     <= '0;
`ifdef BIAS_LOADER_DRAIN_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            loaded_q <= loaded_d;
            q0_q     <= q0_d;
`ifdef BIAS_LOADER_DRAIN_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    always_ff @(posedge ap_clk) begin
        if (mem_we)
            mem[wr_cnt_q] <= input_V_dout;
    end

    assign bias_V_q0 = q0_q;
    assign loaded    = loaded_q;
`ifdef BIAS_LOADER_DRAIN_EN
    assign drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_bias_stream_loader.sv
// Directed bench for bias_stream_loader: NUM_COEFF=4 main instance plus a NUM_COEFF=5
// instance for out-of-range addresses that a 2-bit address cannot express.
module tb_bias_stream_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dout;
    logic        empty_n, rd, reload, ce0, loaded;
    logic [1:0]  addr;
    logic [15:0] q0;
    logic [15:0] dout5;
    logic        empty5, rd5, ce05, loaded5;
    logic [2:0]  addr5;
    logic [15:0] q05;
    logic        reload5;
`ifdef BIAS_LOADER_DRAIN_EN
    logic [15:0] drop_cnt, drop_cnt5;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bias_stream_loader #(.COEFF_WIDTH(16), .NUM_COEFF(4)) u_dut (
        .ap_clk(clk), .ap_rst(rst), .input_V_dout(dout), .input_V_empty_n(empty_n),
        .input_V_read(rd), .reload(reload), .bias_V_address0(addr), .bias_V_ce0(ce0),
        .bias_V_q0(q0),
`ifdef BIAS_LOADER_DRAIN_EN
        .drop_cnt(drop_cnt),
`endif
        .loaded(loaded));

    bias_stream_loader #(.COEFF_WIDTH(16), .NUM_COEFF(5)) u_dut5 (
        .ap_clk(clk), .ap_rst(rst), .input_V_dout(dout5), .input_V_empty_n(empty5),
        .input_V_read(rd5), .reload(reload5), .bias_V_address0(addr5), .bias_V_ce0(ce05),
        .bias_V_q0(q05),
`ifdef BIAS_LOADER_DRAIN_EN
        .drop_cnt(drop_cnt5),
`endif
        .loaded(loaded5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        dout = w;
        empty_n = 1'b1;
        #1 chk("pop_strobe", {31'd0, rd}, 32'd1);
        tick();
        empty_n = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [15:0] exp, input string tag);
        addr = a;
        ce0 = 1'b1;
        tick();
        chk(tag, {16'd0, q0}, {16'd0, exp});
        ce0 = 1'b0;
    endtask

    initial begin
        logic [15:0] tbl [4];
        logic        pat [10];
        int          k;
        rst = 1'b1; dout = '0; empty_n = 1'b0; reload = 1'b0; ce0 = 1'b0; addr = '0;
        dout5 = '0; empty5 = 1'b0; ce05 = 1'b0; addr5 = '0; reload5 = 1'b0;
        tick(); tick();
        chk("rst_q0", {16'd0, q0}, 32'd0);
        chk("rst_loaded", {31'd0, loaded}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: continuous fill, loaded appears after the 4th pop
        tbl[0] = 16'd10; tbl[1] = 16'd20; tbl[2] = 16'd30; tbl[3] = 16'd40;
        for (int i = 0; i < 3; i++) push(tbl[i]);
        chk("loaded_before_last", {31'd0, loaded}, 32'd0);
        push(tbl[3]);
        chk("loaded_after_last", {31'd0, loaded}, 32'd1);
        for (int i = 0; i < 4; i++) rd_chk(2'(i), tbl[i], "t1_read");
        tick();
        chk("ce0_low_holds", {16'd0, q0}, 32'd40);

        // 6: reload coincident with a read still returns the old word
        addr = 2'd1; ce0 = 1'b1; reload = 1'b1;
        tick();
        reload = 1'b0; ce0 = 1'b0;
        chk("reload_read_old", {16'd0, q0}, 32'd20);
        chk("reload_clears_loaded", {31'd0, loaded}, 32'd0);

        // 3 (LOAD part): reads are ignored while loading
        addr = 2'd3; ce0 = 1'b1;
        tick();
        ce0 = 1'b0;
        chk("load_ignores_ce0", {16'd0, q0}, 32'd20);

        // 2: gapped stream 1,0,0,1,...
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        k = 0;
        for (int i = 0; i < 10; i++) begin
            empty_n = pat[i];
            dout = pat[i] ? tbl[k] : 16'hBAD0;
            #1 chk("t2_read_follows_empty_n", {31'd0, rd}, {31'd0, pat[i]});
            if (i == 9) chk("t2_loaded_before_last", {31'd0, loaded}, 32'd0);
            tick();
            if (pat[i]) k++;
        end
        empty_n = 1'b0;
        chk("t2_loaded", {31'd0, loaded}, 32'd1);
        for (int i = 0; i < 4; i++) rd_chk(2'(i), tbl[i], "t2_read");

        // 4: reload after a partial fill
        reload = 1'b1;
        tick();
        reload = 1'b0;
        push(16'd1); push(16'd2);
        dout = 16'd99; empty_n = 1'b1; reload = 1'b1;
        #1 chk("no_pop_in_reload", {31'd0, rd}, 32'd0);
        tick();
        reload = 1'b0; empty_n = 1'b0;
        for (int i = 0; i < 4; i++) push(16'(5 + i));
        chk("t4_loaded", {31'd0, loaded}, 32'd1);
        for (int i = 0; i < 4; i++) rd_chk(2'(i), 16'(5 + i), "t4_read");

        // 4b: async reset mid-load
        reload = 1'b1;
        tick();
        reload = 1'b0;
        push(16'd1); push(16'd2);
        #2 rst = 1'b1;
        #1 chk("rst_mid_q0", {16'd0, q0}, 32'd0);
        chk("rst_mid_loaded", {31'd0, loaded}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push(16'(5 + i));
        chk("t4b_loaded", {31'd0, loaded}, 32'd1);
        rd_chk(2'd0, 16'd5, "t4b_read0");
        rd_chk(2'd3, 16'd8, "t4b_read3");

        // 5: surplus words while READY
        dout = 16'h0777; empty_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
`ifdef BIAS_LOADER_DRAIN_EN
            chk("drain_pop", {31'd0, rd}, 32'd1);
`else
            chk("backpressure", {31'd0, rd}, 32'd0);
`endif
            tick();
        end
        empty_n = 1'b0;
        chk("t5_still_loaded", {31'd0, loaded}, 32'd1);
        rd_chk(2'd1, 16'd6, "t5_table_intact");
`ifdef BIAS_LOADER_DRAIN_EN
        chk("drop_cnt_3", {16'd0, drop_cnt}, 32'd3);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("drop_cnt_cleared", {16'd0, drop_cnt}, 32'd0);
`endif

        // 3: out-of-range address on the NUM_COEFF=5 instance
        for (int i = 0; i < 5; i++) begin
            dout5 = 16'(i + 1); empty5 = 1'b1;
            tick();
        end
        empty5 = 1'b0;
        chk("n5_loaded", {31'd0, loaded5}, 32'd1);
        addr5 = 3'd4; ce05 = 1'b1;
        tick();
        chk("n5_read4", {16'd0, q05}, 32'd5);
        addr5 = 3'd7;
        tick();
        chk("n5_oob_zero", {16'd0, q05}, 32'd0);
        ce05 = 1'b0; addr5 = 3'd0;
        tick();
        chk("n5_oob_hold", {16'd0, q05}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
